// File: rtl/i8228_ctrl_if.sv
// i8228_ctrl bus bundle: CPU status/data side and system strobes.
// master = CPU/system side, slave = controller.
interface i8228_ctrl_if;
  logic       ststb_n;
  logic [7:0] cpu_dout;
  logic       dbin;
  logic       wr_n;
  logic       hlda;
  logic [7:0] sys_din;
  logic [7:0] cpu_din;
  logic       memr_n;
  logic       memw_n;
  logic       ior_n;
  logic       iow_n;
  logic       inta_n;
  logic       busen_n;
  logic [7:0] status;
  logic       cyc_valid;

  modport master (
    output ststb_n, cpu_dout, dbin, wr_n, hlda, sys_din,
    input  cpu_din, memr_n, memw_n, ior_n, iow_n, inta_n,
    input  busen_n, status, cyc_valid
  );

  modport slave (
    input  ststb_n, cpu_dout, dbin, wr_n, hlda, sys_din,
    output cpu_din, memr_n, memw_n, ior_n, iow_n, inta_n,
    output busen_n, status, cyc_valid
  );
endinterface

// File: rtl/i8228_ctrl.sv
// i8228_ctrl: 8080 system controller, latches status on ststb_n
// and produces registered active-low memory/IO/INTA strobes.
module i8228_ctrl #(
  parameter bit RST7_INJECT = 1'b1
) (
  input logic         clk,
  input logic         resetin_n,
  i8228_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    ACTIVE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] st;
  logic       rd_inta;
  logic       rd_inp;
  logic       rd_mem;
  logic       rd_any;
  logic       wr_any;
  logic       memr_q;
  logic       memw_q;
  logic       ior_q;
  logic       iow_q;
  logic       inta_q;
  logic       busen_q;

  // state register
  always_ff @(posedge clk or negedge resetin_n) begin
    if (!resetin_n) state <= IDLE;
    else            state <= state_nx;
  end

  // next state; hold acknowledge wins over everything
  always_comb begin
    state_nx = state;
    if (bus.hlda) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (!bus.ststb_n) state_nx = CAPT;
        CAPT:    if (bus.ststb_n)  state_nx = ACTIVE;
        ACTIVE:  if (!bus.ststb_n) state_nx = CAPT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // strobe candidates: INTA > INP > MEMR, reads beat writes
  always_comb begin
    rd_inta = bus.dbin & st[0];
    rd_inp  = bus.dbin & st[6] & ~st[0];
    rd_mem  = bus.dbin & st[7] & ~st[6] & ~st[0];
    rd_any  = rd_inta | rd_inp | rd_mem;
    wr_any  = ~bus.wr_n & ~st[1] & ~rd_any;
  end

  // registered strobes, only driven while staying in ACTIVE
  always_ff @(posedge clk or negedge resetin_n) begin
    if (!resetin_n) begin
      memr_q <= 1'b1;
      memw_q <= 1'b1;
      ior_q  <= 1'b1;
      iow_q  <= 1'b1;
      inta_q <= 1'b1;
    end else if (state_nx == ACTIVE) begin
      memr_q <= ~rd_mem;
      memw_q <= ~(wr_any & ~st[4]);
      ior_q  <= ~rd_inp;
      iow_q  <= ~(wr_any & st[4]);
      inta_q <= ~rd_inta;
    end else begin
      memr_q <= 1'b1;
      memw_q <= 1'b1;
      ior_q  <= 1'b1;
      iow_q  <= 1'b1;
      inta_q <= 1'b1;
    end
  end

  // status latch: last byte sampled under ststb_n wins
  always_ff @(posedge clk or negedge resetin_n) begin
    if (!resetin_n)                    st <= 8'h00;
    else if (!bus.hlda && !bus.ststb_n) st <= bus.cpu_dout;
  end

  // bus enable follows hold acknowledge
  always_ff @(posedge clk or negedge resetin_n) begin
    if (!resetin_n) busen_q <= 1'b1;
    else            busen_q <= bus.hlda;
  end

  assign bus.memr_n    = memr_q;
  assign bus.memw_n    = memw_q;
  assign bus.ior_n     = ior_q;
  assign bus.iow_n     = iow_q;
  assign bus.inta_n    = inta_q;
  assign bus.busen_n   = busen_q;
  assign bus.status    = st;
  assign bus.cyc_valid = (state == ACTIVE);
  assign bus.cpu_din   = (RST7_INJECT && !inta_q) ? 8'hFF
                                                  : bus.sys_din;

endmodule

// File: tb/tb_i8228_ctrl.sv
// Directed testbench for i8228_ctrl, two instances covering
// RST7_INJECT = 1 and 0 driven with identical stimulus.
module tb_i8228_ctrl;

  logic       clk;
  logic       resetin_n;
  logic       ststb_n;
  logic [7:0] cpu_dout;
  logic       dbin;
  logic       wr_n;
  logic       hlda;
  logic [7:0] sys_din;
  int         checks;
  int         errors;

  i8228_ctrl_if b1 ();
  i8228_ctrl_if b0 ();

  assign b1.ststb_n  = ststb_n;
  assign b1.cpu_dout = cpu_dout;
  assign b1.dbin     = dbin;
  assign b1.wr_n     = wr_n;
  assign b1.hlda     = hlda;
  assign b1.sys_din  = sys_din;
  assign b0.ststb_n  = ststb_n;
  assign b0.cpu_dout = cpu_dout;
  assign b0.dbin     = dbin;
  assign b0.wr_n     = wr_n;
  assign b0.hlda     = hlda;
  assign b0.sys_din  = sys_din;

  i8228_ctrl #(.RST7_INJECT(1'b1)) dut1 (
    .clk       (clk),
    .resetin_n (resetin_n),
    .bus       (b1.slave)
  );

  i8228_ctrl #(.RST7_INJECT(1'b0)) dut0 (
    .clk       (clk),
    .resetin_n (resetin_n),
    .bus       (b0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {memr_n, memw_n, ior_n, iow_n, inta_n}
  function automatic logic [4:0] strb1();
    return {b1.memr_n, b1.memw_n, b1.ior_n, b1.iow_n, b1.inta_n};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cycle(input logic [7:0] s);
    ststb_n  = 1'b0;
    cpu_dout = s;
    tick();
    tick();
    ststb_n  = 1'b1;
    cpu_dout = 8'h00;
    tick();
  endtask

  task automatic test_reset();
    resetin_n = 1'b0;
    ststb_n = 1'b1; cpu_dout = 8'h00; dbin = 1'b0;
    wr_n = 1'b1; hlda = 1'b0; sys_din = 8'h00;
    tick();
    tick();
    checks++;
    if ({strb1(), b1.busen_n, b1.cyc_valid, b1.status} !== {5'b11111, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got strb=%b busen=%b cv=%b st=%h required 11111 1 0 00",
               strb1(), b1.busen_n, b1.cyc_valid, b1.status);
    end
    resetin_n = 1'b1;
    tick();
    checks++;
    if (b1.busen_n !== 1'b0) begin
      errors++;
      $display("FAIL reset_busen: got %b required 0", b1.busen_n);
    end
  endtask

  task automatic test_mem_read();
    ststb_n  = 1'b0;
    cpu_dout = 8'hA2;
    tick();
    checks++;
    if (b1.status !== 8'hA2) begin
      errors++;
      $display("FAIL rd_status_lat: got %h required a2", b1.status);
    end
    tick();
    ststb_n  = 1'b1;
    cpu_dout = 8'h00;
    tick();
    checks++;
    if ({b1.cyc_valid, strb1()} !== 6'b1_11111) begin
      errors++;
      $display("FAIL rd_active: got cv=%b strb=%b required 1 11111",
               b1.cyc_valid, strb1());
    end
    dbin = 1'b1;
    sys_din = 8'h3C;
    #1;
    checks++;
    if (b1.memr_n !== 1'b1) begin
      errors++;
      $display("FAIL rd_latency: got memr_n=%b required 1", b1.memr_n);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({strb1(), b1.cpu_din} !== {5'b01111, 8'h3C}) begin
        errors++;
        $display("FAIL rd_pulse%0d: got strb=%b din=%h required 01111 3c",
                 i, strb1(), b1.cpu_din);
      end
    end
    dbin = 1'b0;
    tick();
    checks++;
    if (strb1() !== 5'b11111) begin
      errors++;
      $display("FAIL rd_end: got %b required 11111", strb1());
    end
  endtask

  task automatic test_mem_write();
    start_cycle(8'h00);
    wr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (strb1() !== 5'b10111) begin
        errors++;
        $display("FAIL wr_pulse%0d: got %b required 10111", i, strb1());
      end
    end
    wr_n = 1'b1;
    tick();
    checks++;
    if (strb1() !== 5'b11111) begin
      errors++;
      $display("FAIL wr_end: got %b required 11111", strb1());
    end
  endtask

  task automatic test_io();
    start_cycle(8'h10);
    wr_n = 1'b0;
    tick();
    checks++;
    if (strb1() !== 5'b11101) begin
      errors++;
      $display("FAIL io_out: got %b required 11101", strb1());
    end
    wr_n = 1'b1;
    tick();
    start_cycle(8'h42);
    dbin = 1'b1;
    tick();
    checks++;
    if (strb1() !== 5'b11011) begin
      errors++;
      $display("FAIL io_in: got %b required 11011", strb1());
    end
    dbin = 1'b0;
    tick();
  endtask

  task automatic test_inta();
    start_cycle(8'h23);
    sys_din = 8'h00;
    dbin = 1'b1;
    tick();
    checks++;
    if ({strb1(), b1.cpu_din} !== {5'b11110, 8'hFF}) begin
      errors++;
      $display("FAIL inta_rst7: got strb=%b din=%h required 11110 ff",
               strb1(), b1.cpu_din);
    end
    checks++;
    if ({b0.inta_n, b0.memr_n, b0.cpu_din} !== {2'b01, 8'h00}) begin
      errors++;
      $display("FAIL inta_noinj: got inta=%b memr=%b din=%h required 0 1 00",
               b0.inta_n, b0.memr_n, b0.cpu_din);
    end
    dbin = 1'b0;
    tick();
  endtask

  task automatic test_priority();
    start_cycle(8'hC2);
    dbin = 1'b1;
    tick();
    checks++;
    if (strb1() !== 5'b11011) begin
      errors++;
      $display("FAIL prio_inp: got %b required 11011", strb1());
    end
    dbin = 1'b0;
    tick();
    start_cycle(8'h0A);
    tick();
    tick();
    checks++;
    if ({b1.cyc_valid, strb1()} !== 6'b1_11111) begin
      errors++;
      $display("FAIL halt: got cv=%b strb=%b required 1 11111",
               b1.cyc_valid, strb1());
    end
  endtask

  task automatic test_hold();
    start_cycle(8'hA2);
    dbin = 1'b1;
    tick();
    checks++;
    if ({b1.memr_n, b1.busen_n} !== 2'b00) begin
      errors++;
      $display("FAIL hold_pre: got memr=%b busen=%b required 0 0",
               b1.memr_n, b1.busen_n);
    end
    hlda = 1'b1;
    tick();
    checks++;
    if ({b1.memr_n, b1.busen_n, b1.cyc_valid} !== 3'b110) begin
      errors++;
      $display("FAIL hold: got memr=%b busen=%b cv=%b required 1 1 0",
               b1.memr_n, b1.busen_n, b1.cyc_valid);
    end
    hlda = 1'b0;
    dbin = 1'b0;
    tick();
    start_cycle(8'hA2);
    dbin = 1'b1;
    tick();
    checks++;
    if ({strb1(), b1.busen_n} !== {5'b01111, 1'b0}) begin
      errors++;
      $display("FAIL hold_resume: got strb=%b busen=%b required 01111 0",
               strb1(), b1.busen_n);
    end
    ststb_n = 1'b0;
    cpu_dout = 8'hA2;
    tick();
    checks++;
    if ({b1.cyc_valid, strb1()} !== 6'b0_11111) begin
      errors++;
      $display("FAIL stb_abort: got cv=%b strb=%b required 0 11111",
               b1.cyc_valid, strb1());
    end
    ststb_n = 1'b1;
    dbin = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start_cycle(8'h00);
    wr_n = 1'b0;
    tick();
    checks++;
    if (b1.memw_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: got memw=%b required 0", b1.memw_n);
    end
    #2;
    resetin_n = 1'b0;
    #1;
    checks++;
    if ({strb1(), b1.status, b1.cyc_valid} !== {5'b11111, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_async: got strb=%b st=%h cv=%b required 11111 00 0",
               strb1(), b1.status, b1.cyc_valid);
    end
    wr_n = 1'b1;
    tick();
    resetin_n = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mem_read();
    test_mem_write();
    test_io();
    test_inta();
    test_priority();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
